pad_scan_sequencer: RTL and testbench

//  Sequences the serial game-pad port: periodically latches the pad, clocks out
//  P_NUM_BITS serial bits, and presents an 8-bit active-low button snapshot to the
//  P1/joypad register logic. Also emits a new-press event strobe for the joypad

---
 rtl/pad_scan_sequencer.sv | 186 ++++++++++++++++++
 tb/tb_pad_scan_sequencer.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pad_scan_sequencer.sv
// Serial game-pad scan sequencer: periodically latches a NES/SNES pad, clocks out its
// serial bits and publishes an active-low button byte with update/press/error strobes.
module pad_scan_sequencer #(
  parameter int P_LATCH_CYCLES = 396,
  parameter int P_HALF_CYCLES  = 198,
  parameter int P_POLL_CYCLES  = 550000,
  parameter int P_NUM_BITS     = 16
) (
  input  logic       i_clk_33mhz,
  input  logic       i_reset_l,
  input  logic       i_enable,
  input  logic       i_data,
  output logic       o_latch,
  output logic       o_pulse,
  output logic [7:0] o_buttons,
  output logic       o_valid,
  output logic       o_press_event,
  output logic       o_scan_err
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_LATCH    = 3'd1;
  localparam logic [2:0] S_PULSE_LO = 3'd2;
  localparam logic [2:0] S_PULSE_HI = 3'd3;
  localparam logic [2:0] S_DONE     = 3'd4;

  localparam int C_PH_MAX = (P_LATCH_CYCLES > P_HALF_CYCLES) ? P_LATCH_CYCLES : P_HALF_CYCLES;
  localparam int C_PH_W   = (C_PH_MAX > 1) ? $clog2(C_PH_MAX) : 1;
  localparam int C_POLL_W = (P_POLL_CYCLES > 1) ? $clog2(P_POLL_CYCLES) : 1;
  localparam int C_IDX_W  = (P_NUM_BITS > 1) ? $clog2(P_NUM_BITS) : 1;

  localparam logic [C_PH_W-1:0]   C_LATCH_LAST = C_PH_W'(P_LATCH_CYCLES - 1);
  localparam logic [C_PH_W-1:0]   C_HALF_LAST  = C_PH_W'(P_HALF_CYCLES - 1);
  localparam logic [C_POLL_W-1:0] C_POLL_LAST  = C_POLL_W'(P_POLL_CYCLES - 1);
  localparam logic [C_IDX_W-1:0]  C_IDX_LAST   = C_IDX_W'(P_NUM_BITS - 1);

  logic [2:0]            r_state;
  logic [2:0]            w_nextState;
  logic [C_PH_W-1:0]     r_phaseCnt;
  logic [C_POLL_W-1:0]   r_pollCnt;
  logic [C_IDX_W-1:0]    r_bitIdx;
  logic [P_NUM_BITS-1:0] r_shift;
  logic [1:0]            r_dataSync;
  logic                  w_phaseEnd;
  logic                  w_scanEnd;
  logic                  w_idBad;
  logic [7:0]            w_map;

  logic                  r_latch;
  logic                  r_pulse;
  logic [7:0]            r_buttons;
  logic                  r_valid;
  logic                  r_pressEvent;
  logic                  r_scanErr;

  // Pad data is asynchronous; reset to "released" so no phantom press is seen.
  always_ff @(posedge i_clk_33mhz or negedge i_reset_l) begin
    if (!i_reset_l) begin
      r_dataSync <= 2'b11;
    end else begin
      r_dataSync <= {r_dataSync[0], i_data};
    end
  end

  always_ff @(posedge i_clk_33mhz or negedge i_reset_l) begin
    if (!i_reset_l) begin
      r_pollCnt <= '0;
    end else if (!i_enable || (r_pollCnt == C_POLL_LAST)) begin
      r_pollCnt <= '0;
    end else begin
      r_pollCnt <= r_pollCnt + C_POLL_W'(1);
    end
  end

  always_comb begin
    w_nextState = r_state;
    w_phaseEnd  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_enable && (r_pollCnt == '0)) begin
          w_nextState = S_LATCH;
        end
      end
      S_LATCH: begin
        if (r_phaseCnt == C_LATCH_LAST) begin
          w_phaseEnd  = 1'b1;
          w_nextState = S_PULSE_LO;
        end
      end
      S_PULSE_LO: begin
        if (r_phaseCnt == C_HALF_LAST) begin
          w_phaseEnd  = 1'b1;
          w_nextState = S_PULSE_HI;
        end
      end
      S_PULSE_HI: begin
        if (r_phaseCnt == C_HALF_LAST) begin
          w_phaseEnd  = 1'b1;
          w_nextState = (r_bitIdx == C_IDX_LAST) ? S_DONE : S_PULSE_LO;
        end
      end
      S_DONE:  w_nextState = S_IDLE;
      default: w_nextState = S_IDLE;
    endcase
  end

  assign w_scanEnd = (r_state == S_PULSE_HI) && (w_nextState == S_DONE);

  // Bit index wraps on the last bit rather than reaching P_NUM_BITS, so it never overflows.
  always_ff @(posedge i_clk_33mhz or negedge i_reset_l) begin
    if (!i_reset_l) begin
      r_state    <= S_IDLE;
      r_phaseCnt <= '0;
      r_bitIdx   <= '0;
    end else begin
      r_state <= w_nextState;
      if (w_phaseEnd || (r_state == S_IDLE) || (r_state == S_DONE)) begin
        r_phaseCnt <= '0;
      end else begin
        r_phaseCnt <= r_phaseCnt + C_PH_W'(1);
      end
      if (r_state == S_IDLE) begin
        r_bitIdx <= '0;
      end else if ((r_state == S_PULSE_HI) && w_phaseEnd) begin
        r_bitIdx <= (r_bitIdx == C_IDX_LAST) ? '0 : r_bitIdx + C_IDX_W'(1);
      end
    end
  end

  always_ff @(posedge i_clk_33mhz or negedge i_reset_l) begin
    if (!i_reset_l) begin
      r_shift <= '1;
    end else if ((r_state == S_PULSE_LO) && w_phaseEnd) begin
      r_shift[r_bitIdx] <= r_dataSync[1];
    end
  end

  generate
    if (P_NUM_BITS == 16) begin : g_snes
      logic w_unused;
      assign w_unused = ^{r_shift[11:9], r_shift[1]};
      assign w_map   = {r_shift[3], r_shift[2], r_shift[0], r_shift[8],
                        r_shift[5], r_shift[4], r_shift[6], r_shift[7]};
      assign w_idBad = ~&r_shift[15:12];
    end else begin : g_nes
      assign w_map   = {r_shift[3], r_shift[2], r_shift[1], r_shift[0],
                        r_shift[5], r_shift[4], r_shift[6], r_shift[7]};
      assign w_idBad = 1'b0;
    end
  endgenerate

  // Pad strobes come from dedicated flops keyed on the next state so they cannot glitch.
  always_ff @(posedge i_clk_33mhz or negedge i_reset_l) begin
    if (!i_reset_l) begin
      r_latch      <= 1'b0;
      r_pulse      <= 1'b1;
      r_buttons    <= 8'hFF;
      r_valid      <= 1'b0;
      r_pressEvent <= 1'b0;
      r_scanErr    <= 1'b0;
    end else begin
      r_latch      <= (w_nextState == S_LATCH);
      r_pulse      <= (w_nextState != S_PULSE_LO);
      r_valid      <= 1'b0;
      r_pressEvent <= 1'b0;
      r_scanErr    <= 1'b0;
      if (w_scanEnd) begin
        if (w_idBad) begin
          r_scanErr <= 1'b1;
        end else begin
          r_buttons    <= w_map;
          r_valid      <= 1'b1;
          r_pressEvent <= |(r_buttons & ~w_map);
        end
      end
    end
  end

  assign o_latch       = r_latch;
  assign o_pulse       = r_pulse;
  assign o_buttons     = r_buttons;
  assign o_valid       = r_valid;
  assign o_press_event = r_pressEvent;
  assign o_scan_err    = r_scanErr;

endmodule

// File: tb/tb_pad_scan_sequencer.sv
// Bench for pad_scan_sequencer: a pad model drives serial data, a timeline model of the
// scan predicts every output each cycle, and directed scenarios pin literal values.
module tb_pad_scan_sequencer;

  localparam int L       = 4;
  localparam int H       = 2;
  localparam int POLL    = 200;
  localparam int NB      = 16;
  localparam int SCANLEN = L + 2 * H * NB + 1;

  logic        clk = 1'b0;
  logic        rstN;
  logic        enable;
  logic        data;
  logic        oLatch;
  logic        oPulse;
  logic [7:0]  oButtons;
  logic        oValid;
  logic        oPress;
  logic        oErr;
  logic [15:0] padPattern;
  logic [15:0] padShift;
  int          errors = 0;
  int          checks = 0;

  pad_scan_sequencer #(
    .P_LATCH_CYCLES(L),
    .P_HALF_CYCLES (H),
    .P_POLL_CYCLES (POLL),
    .P_NUM_BITS    (NB)
  ) dut (
    .i_clk_33mhz  (clk),
    .i_reset_l    (rstN),
    .i_enable     (enable),
    .i_data       (data),
    .o_latch      (oLatch),
    .o_pulse      (oPulse),
    .o_buttons    (oButtons),
    .o_valid      (oValid),
    .o_press_event(oPress),
    .o_scan_err   (oErr)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // SNES serial order -> {START,SELECT,B,A,DOWN,UP,LEFT,RIGHT}
  function automatic logic [7:0] mapPad(input logic [15:0] p);
    logic [7:0] b;
    b[7] = p[3];
    b[6] = p[2];
    b[5] = p[0];
    b[4] = p[8];
    b[3] = p[5];
    b[2] = p[4];
    b[1] = p[6];
    b[0] = p[7];
    return b;
  endfunction

  task automatic padLoop();
    forever begin
      @(posedge oLatch or posedge oPulse);
      #1;
      if (oLatch) padShift = padPattern;
      else        padShift = {1'b1, padShift[15:1]};
      data = padShift[0];
    end
  endtask

  // Scan timeline: offset k counts cycles since the edge that started the scan.
  task automatic modelLoop();
    int         k;
    int         poll;
    logic       busy;
    logic [15:0] pat;
    logic [7:0] btn;
    logic [7:0] newBtn;
    logic       eLatch;
    logic       ePulse;
    logic       eValid;
    logic       eEvent;
    logic       eErr;
    busy = 1'b0;
    k    = 0;
    poll = 0;
    btn  = 8'hFF;
    pat  = '1;
    forever begin
      @(posedge clk or negedge rstN);
      eValid = 1'b0;
      eEvent = 1'b0;
      eErr   = 1'b0;
      if (!rstN) begin
        busy = 1'b0;
        k    = 0;
        poll = 0;
        btn  = 8'hFF;
      end else begin
        if (busy) begin
          k++;
          if (k == SCANLEN) busy = 1'b0;
        end else if (enable && poll == 0) begin
          busy = 1'b1;
          k    = 0;
          pat  = padPattern;
        end
        poll = enable ? (poll + 1) % POLL : 0;
        if (busy && k == SCANLEN - 1) begin
          if (pat[15:12] != 4'hF) begin
            eErr = 1'b1;
          end else begin
            newBtn = mapPad(pat);
            eEvent = |(btn & ~newBtn);
            btn    = newBtn;
            eValid = 1'b1;
          end
        end
      end
      eLatch = busy && (k < L);
      ePulse = !(busy && (k >= L) && (k < L + 2 * H * NB) && (((k - L) % (2 * H)) < H));
      #1;
      checkOutput("m_latch",   16'(oLatch),   16'(eLatch));
      checkOutput("m_pulse",   16'(oPulse),   16'(ePulse));
      checkOutput("m_buttons", 16'(oButtons), 16'(btn));
      checkOutput("m_valid",   16'(oValid),   16'(eValid));
      checkOutput("m_event",   16'(oPress),   16'(eEvent));
      checkOutput("m_err",     16'(oErr),     16'(eErr));
    end
  endtask

  task automatic applyStimulus(input logic en, input logic [15:0] pat);
    @(negedge clk);
    enable     = en;
    padPattern = pat;
  endtask

  task automatic waitStrobe(input string name);
    for (int n = 0; n < 400; n++) begin
      @(posedge clk);
      #1;
      if (oValid || oErr) break;
    end
    checkOutput({name, "_strobe"}, 16'(oValid | oErr), 16'd1);
  endtask

  task automatic waitPulseFalls(input int num);
    int   cnt;
    logic prev;
    cnt  = 0;
    prev = oPulse;
    for (int n = 0; n < 400; n++) begin
      @(posedge clk);
      #1;
      if (prev && !oPulse) cnt++;
      prev = oPulse;
      if (cnt == num) break;
    end
    checkOutput("pulse_falls", 16'(cnt), 16'(num));
  endtask

  initial begin
    int   latchCnt;
    int   lowCyc;
    int   lowPh;
    int   validCyc;
    logic prevPulse;
    rstN       = 1'b0;
    enable     = 1'b0;
    padPattern = 16'hFFFF;
    padShift   = 16'hFFFF;
    data       = 1'b1;
    fork
      padLoop();
      modelLoop();
    join_none

    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_latch",   16'(oLatch),   16'd0);
    checkOutput("rst_pulse",   16'(oPulse),   16'd1);
    checkOutput("rst_buttons", 16'(oButtons), 16'hFF);
    checkOutput("rst_valid",   16'(oValid),   16'd0);

    // Scenario 1: first scan timing with a released pad
    @(negedge clk);
    enable = 1'b1;
    rstN   = 1'b1;
    latchCnt = 0; lowCyc = 0; lowPh = 0; validCyc = 0; prevPulse = 1'b1;
    for (int cyc = 1; cyc <= 300; cyc++) begin
      @(posedge clk);
      #1;
      if (oLatch) latchCnt++;
      if (!oPulse) lowCyc++;
      if (!oPulse && prevPulse) lowPh++;
      prevPulse = oPulse;
      if (oValid) begin
        validCyc = cyc;
        break;
      end
    end
    checkOutput("s1_valid_cycle", 16'(validCyc), 16'd69);
    checkOutput("s1_latch_cycles", 16'(latchCnt), 16'd4);
    checkOutput("s1_low_phases", 16'(lowPh), 16'd16);
    checkOutput("s1_low_cycles", 16'(lowCyc), 16'd32);
    checkOutput("s1_buttons", 16'(oButtons), 16'hFF);
    checkOutput("s1_event", 16'(oPress), 16'd0);

    // Scenario 2: A and UP pressed, then held
    applyStimulus(1'b1, 16'hFEEF);
    waitStrobe("s2a");
    checkOutput("s2a_valid", 16'(oValid), 16'd1);
    checkOutput("s2a_buttons", 16'(oButtons), 16'hEB);
    checkOutput("s2a_event", 16'(oPress), 16'd1);
    waitStrobe("s2b");
    checkOutput("s2b_buttons", 16'(oButtons), 16'hEB);
    checkOutput("s2b_event", 16'(oPress), 16'd0);

    // Scenario 3: release A, hold UP
    applyStimulus(1'b1, 16'hFFEF);
    waitStrobe("s3");
    checkOutput("s3_buttons", 16'(oButtons), 16'hFB);
    checkOutput("s3_event", 16'(oPress), 16'd0);

    // Scenario 4: bad ID bit 13
    applyStimulus(1'b1, 16'hDFEF);
    waitStrobe("s4");
    checkOutput("s4_err", 16'(oErr), 16'd1);
    checkOutput("s4_valid", 16'(oValid), 16'd0);
    checkOutput("s4_buttons", 16'(oButtons), 16'hFB);

    // Scenario 5: drop enable during bit 5 low phase
    applyStimulus(1'b1, 16'hFFEF);
    for (int n = 0; n < 400; n++) begin
      @(posedge clk);
      #1;
      if (oLatch) break;
    end
    checkOutput("s5_latch_seen", 16'(oLatch), 16'd1);
    waitPulseFalls(6);
    applyStimulus(1'b0, 16'hFFEF);
    waitStrobe("s5");
    checkOutput("s5_valid", 16'(oValid), 16'd1);
    checkOutput("s5_buttons", 16'(oButtons), 16'hFB);
    latchCnt = 0;
    for (int n = 0; n < 1000; n++) begin
      @(posedge clk);
      #1;
      if (oLatch) latchCnt++;
    end
    checkOutput("s5_no_latch", 16'(latchCnt), 16'd0);
    applyStimulus(1'b1, 16'hFFEF);
    @(posedge clk);
    #1;
    checkOutput("s5_reenable_latch", 16'(oLatch), 16'd1);

    // Scenario 6: asynchronous reset mid PULSE_LO
    waitPulseFalls(3);
    #2;
    rstN = 1'b0;
    #1;
    checkOutput("s6_pulse", 16'(oPulse), 16'd1);
    checkOutput("s6_latch", 16'(oLatch), 16'd0);
    checkOutput("s6_buttons", 16'(oButtons), 16'hFF);
    repeat (3) @(negedge clk);
    rstN = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("s6_restart_latch", 16'(oLatch), 16'd1);
    waitStrobe("s6");
    checkOutput("s6_valid", 16'(oValid), 16'd1);
    checkOutput("s6_buttons_after", 16'(oButtons), 16'hFB);
    checkOutput("s6_event", 16'(oPress), 16'd1);

    repeat (4) @(posedge clk);
    #2;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
